// File: rtl/traffic_light.sv
// rtl/traffic_light.sv - four-phase two-way intersection light controller
module traffic_light #(
    parameter int S1_CYCLES = 3,
    parameter int S2_CYCLES = 15,
    parameter int S3_CYCLES = 3,
    parameter int S4_CYCLES = 15
) (
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] ns,
    output logic [2:0] we
);

    localparam int MAX_12 = (S1_CYCLES > S2_CYCLES) ? S1_CYCLES : S2_CYCLES;
    localparam int MAX_34 = (S3_CYCLES > S4_CYCLES) ? S3_CYCLES : S4_CYCLES;
    localparam int MAX_CYCLES = (MAX_12 > MAX_34) ? MAX_12 : MAX_34;
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    // One-hot encoding so a corrupted register lands in the all-red default branch.
    typedef enum logic [3:0] {
        s1 = 4'b0001,
        s2 = 4'b0010,
        s3 = 4'b0100,
        s4 = 4'b1000
    } state_t;

    state_t        state;
    state_t        next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic          legal;

    always_comb begin
        last  = '0;
        next  = s1;
        legal = 1'b1;
        case (state)
            s1: begin last = CW'(S1_CYCLES - 1); next = s2; end
            s2: begin last = CW'(S2_CYCLES - 1); next = s3; end
            s3: begin last = CW'(S3_CYCLES - 1); next = s4; end
            s4: begin last = CW'(S4_CYCLES - 1); next = s1; end
            default: begin last = '0; next = s1; legal = 1'b0; end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= s1;
            cnt   <= '0;
        end else if (!legal || cnt >= last) begin
            state <= next;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Lamp vectors are {red, yellow, green}.
    always_comb begin
        ns = 3'b100;
        we = 3'b100;
        case (state)
            s1: begin ns = 3'b100; we = 3'b010; end
            s2: begin ns = 3'b001; we = 3'b100; end
            s3: begin ns = 3'b010; we = 3'b100; end
            s4: begin ns = 3'b100; we = 3'b001; end
            default: begin ns = 3'b100; we = 3'b100; end
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// tb/tb_traffic_light.sv - randomized check of traffic_light against a phase-arithmetic model
module tb_traffic_light;

    logic       clock;
    logic       rst_a, rst_b, rst_c;
    logic [2:0] ns_a, we_a, ns_b, we_b, ns_c, we_c;
    int         n_a, n_b, n_c;
    int         passed, total;

    traffic_light dut_a (.clock(clock), .reset(rst_a), .ns(ns_a), .we(we_a));

    traffic_light #(.S1_CYCLES(3), .S2_CYCLES(4), .S3_CYCLES(3), .S4_CYCLES(4))
        dut_b (.clock(clock), .reset(rst_b), .ns(ns_b), .we(we_b));

    traffic_light #(.S1_CYCLES(1), .S2_CYCLES(1), .S3_CYCLES(1), .S4_CYCLES(2))
        dut_c (.clock(clock), .reset(rst_c), .ns(ns_c), .we(we_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Number of dwell edges elapsed since each DUT last left reset.
    always @(posedge clock) begin
        if (rst_a) n_a = n_a + 1;
        if (rst_b) n_b = n_b + 1;
        if (rst_c) n_c = n_c + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            passed = passed + 1;
    endtask

    function automatic logic [5:0] model(input int d1, input int d2, input int d3,
                                         input int d4, input int n);
        int x;
        x = n % (d1 + d2 + d3 + d4);
        if (x < d1)                return {3'b100, 3'b010};
        else if (x < d1 + d2)      return {3'b001, 3'b100};
        else if (x < d1 + d2 + d3) return {3'b010, 3'b100};
        else                       return {3'b100, 3'b001};
    endfunction

    task automatic check_dut(input string tag, input logic [2:0] ns, input logic [2:0] we,
                             input logic [5:0] exp);
        check({tag, "_ns"}, 32'(ns), 32'(exp[5:3]));
        check({tag, "_we"}, 32'(we), 32'(exp[2:0]));
        check({tag, "_onehot"}, 32'($countones(ns) + $countones(we)), 32'd2);
        check({tag, "_notbothgreen"}, 32'(ns[0] & we[0]), 32'd0);
    endtask

    task automatic check_all();
        check_dut("a", ns_a, we_a, model(3, 15, 3, 15, n_a));
        check_dut("b", ns_b, we_b, model(3, 4, 3, 4, n_b));
        check_dut("c", ns_c, we_c, model(1, 1, 1, 2, n_c));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check_all();
        end
    endtask

    initial begin
        int which, guard;
        passed = 0;
        total  = 0;
        n_a = 0; n_b = 0; n_c = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        repeat (2) @(negedge clock);
        check_dut("rst_a", ns_a, we_a, {3'b100, 3'b010});
        check_dut("rst_b", ns_b, we_b, {3'b100, 3'b010});
        check_dut("rst_c", ns_c, we_c, {3'b100, 3'b010});
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        run(80);

        // Directed asynchronous reset in the middle of dut_a's green phase.
        guard = 0;
        while ((n_a % 36) != 10 && guard < 100) begin
            @(negedge clock);
            check_all();
            guard++;
        end
        check("reach_s2_cycle10", 32'(n_a % 36), 32'd10);
        #2;
        rst_a = 1'b0;
        n_a   = 0;
        #1;
        check_dut("async_a", ns_a, we_a, {3'b100, 3'b010});
        @(negedge clock);
        check_dut("held_a", ns_a, we_a, {3'b100, 3'b010});
        rst_a = 1'b1;
        run(40);

        // Random reset pulses on random instances at random points in the cycle.
        for (int k = 0; k < 25; k++) begin
            run($urandom_range(60, 0));
            which = $urandom_range(2, 0);
            #($urandom_range(4, 1));
            case (which)
                0: begin rst_a = 1'b0; n_a = 0; end
                1: begin rst_b = 1'b0; n_b = 0; end
                default: begin rst_c = 1'b0; n_c = 0; end
            endcase
            #1;
            check_all();
            repeat ($urandom_range(2, 1)) begin
                @(negedge clock);
                check_all();
            end
            rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        end
        run(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
- Four-phase traffic-light controller for a two-way intersection: north-south (ns) and west-east (we).
- Moore FSM with a dwell counter cycles s1→s2→s3→s4→s1 using fixed per-state durations in clock cycles.
- Drives two 3-bit lamp vectors.
- Standalone leaf block clocked by the system clock.

Parameters:
- S1_CYCLES, 3, dwell of s1 (WE yellow, NS red); must be ≥1
- S2_CYCLES, 15, dwell of s2 (NS green, WE red); must be ≥1
- S3_CYCLES, 3, dwell of s3 (NS yellow, WE red); must be ≥1
- S4_CYCLES, 15, dwell of s4 (WE green, NS red); must be ≥1

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset; 0 = in reset
- ns  output  3  north-south lamps {red, yellow, green}, one-hot
- we  output  3  west-east lamps {red, yellow, green}, one-hot

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Internal state register `state` holds one of four states: s1, s2, s3, s4. Names `state`, `s1`..`s4` are kept for hierarchical assertions.
- Internal dwell counter `cnt`, width = clog2(max Sx_CYCLES)+1.
- Reset asserted (reset=0), taking effect immediately without waiting for a clock edge:
  - state=s1, cnt=0.
  - Outputs ns=3'b100, we=3'b010.
- After reset release, the first rising edge counts as s1's first dwell cycle.
- Each state holds for exactly its Sx_CYCLES rising edges, then moves to the next state:
  - Counter increments each clock while cnt < Sx_CYCLES-1.
  - When cnt == Sx_CYCLES-1: advance state, clear cnt to 0.
- Transitions: s1→s2→s3→s4→s1. There are no other transitions and no external inputs besides reset.
- Default timing:
  - s1 for 3 cycles, s2 for 15, s3 for 3, s4 for 15.
  - Full period 36 cycles.
- Outputs are combinational Moore decode of `state` only (no glitch-free registering required):
  - s1: ns=100 (red), we=010 (yellow)
  - s2: ns=001 (green), we=100 (red)
  - s3: ns=010 (yellow), we=100 (red)
  - s4: ns=100 (red), we=001 (green)
- Safety invariants, every cycle:
  - ns and we are each exactly one-hot.
  - ns and we are never both non-red except s1 (WE yellow) / s3 (NS yellow) with the other side red.
  - Never both green.
- Illegal/unreachable state encoding: next state = s1, cnt=0; outputs ns=100, we=100 (all red).
- Reset mid-operation, in any state at any count: immediately to s1, cnt=0. Full s1 dwell restarts after release.
- Sx_CYCLES=1: the state lasts exactly one cycle.

Test Plan:
- Reset held low 1 cycle, then released → at first posedge after release state==s1, ns=100, we=010.
- Free-run from reset release (cycle 0 = first posedge) → s1 at cycles 0–2, s2 at 3–17, s3 at 18–20, s4 at 21–35, s1 again at 36.
- Duration checks over 50 cycles:
  - Every entry into s1 is followed by 3 cycles of s1 then s2.
  - Every s1→s2 is followed by 15 cycles of s2 then s3.
  - Every s2→s3 is followed by 3 cycles of s3 then s4.
  - Every s3→s4 is followed by 15 cycles of s4 then s1.
  - Whenever s1→s2 occurs, state was s1 three cycles earlier.
- Output decode per state as listed. Assertion: ns and we one-hot every cycle, never both green.
- Assert reset low asynchronously mid-s2 (cycle 10, between edges) → state=s1 and ns=100/we=010 before the next edge. After release, 3 cycles of s1 then s2.
- Re-parameterise S2_CYCLES=4, S4_CYCLES=4 → period 14 cycles, s2 at cycles 3–6, s3 at 7–9, s4 at 10–13.
